// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
// One request is outstanding at most; a response is a single-cycle rvalid pulse.
interface fetch_stage_if #(
  parameter int unsigned XLEN = 64
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// RISC-V instruction-fetch stage: owns the PC, fetches one word at a time from imem and
// holds it in the IF/ID register backed by a one-entry skid buffer; handles stall and redirect.
module fetch_stage #(
  parameter int unsigned     XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  fetch_stage_if.master   imem,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic [6:0]      opcode
);

  localparam logic [XLEN-1:0] ResetPcAligned = {RESET_PC[XLEN-1:2], 2'b00};
  localparam logic [XLEN-1:0] PcStep         = {{(XLEN-3){1'b0}}, 3'b100};

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StFull
  } stateT;

  stateT           stateQ, stateD;
  logic [XLEN-1:0] pcQ, pcD;
  logic            ifValidQ, ifValidD;
  logic [XLEN-1:0] ifPcQ, ifPcD;
  logic [31:0]     ifInstrQ, ifInstrD;
  logic [XLEN-1:0] skidPcQ, skidPcD;
  logic [31:0]     skidInstrQ, skidInstrD;
  logic            discardQ, discardD;

  logic            ifFree;
  logic            respInWait;
  logic [XLEN-1:0] pcPlus4;

  assign ifFree     = !ifValidQ || !stall;
  assign respInWait = (stateQ == StWait) && imem.imem_rvalid;
  assign pcPlus4    = pcQ + PcStep;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateQ     <= StIdle;
      pcQ        <= ResetPcAligned;
      ifValidQ   <= 1'b0;
      ifPcQ      <= '0;
      ifInstrQ   <= NOP_INSTR;
      skidPcQ    <= '0;
      skidInstrQ <= NOP_INSTR;
      discardQ   <= 1'b0;
    end else begin
      stateQ     <= stateD;
      pcQ        <= pcD;
      ifValidQ   <= ifValidD;
      ifPcQ      <= ifPcD;
      ifInstrQ   <= ifInstrD;
      skidPcQ    <= skidPcD;
      skidInstrQ <= skidInstrD;
      discardQ   <= discardD;
    end
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:  stateD = StIssue;
      StIssue: stateD = StWait;
      StWait: begin
        if (imem.imem_rvalid) begin
          stateD = (discardQ || ifFree) ? StIssue : StFull;
        end
      end
      StFull: begin
        if (!stall) begin
          stateD = StIssue;
        end
      end
      default: stateD = StIdle;
    endcase
    // A redirect with a request in flight must still wait for that response to drain.
    if (branch_taken) begin
      if (stateQ == StWait) begin
        stateD = imem.imem_rvalid ? StIssue : StWait;
      end else if (stateQ == StIssue) begin
        stateD = StWait;
      end else begin
        stateD = StIssue;
      end
    end
  end

  always_comb begin
    pcD        = pcQ;
    ifValidD   = ifValidQ;
    ifPcD      = ifPcQ;
    ifInstrD   = ifInstrQ;
    skidPcD    = skidPcQ;
    skidInstrD = skidInstrQ;
    discardD   = discardQ;

    if (ifValidQ && !stall) begin
      ifValidD = 1'b0;
      ifInstrD = NOP_INSTR;
    end

    if (branch_taken) begin
      pcD        = {branch_target[XLEN-1:2], 2'b00};
      ifValidD   = 1'b0;
      ifInstrD   = NOP_INSTR;
      skidInstrD = NOP_INSTR;
      // Only a response still to come needs dropping; one arriving now is dropped directly.
      discardD   = (stateQ == StIssue) || ((stateQ == StWait) && !imem.imem_rvalid);
    end else if (respInWait) begin
      if (discardQ) begin
        discardD = 1'b0;
      end else if (ifFree) begin
        ifValidD = 1'b1;
        ifInstrD = imem.imem_rdata;
        ifPcD    = pcQ;
        pcD      = pcPlus4;
      end else begin
        skidInstrD = imem.imem_rdata;
        skidPcD    = pcQ;
      end
    end else if ((stateQ == StFull) && !stall) begin
      ifValidD = 1'b1;
      ifInstrD = skidInstrQ;
      ifPcD    = skidPcQ;
      pcD      = pcPlus4;
    end
  end

  always_comb begin
    imem.imem_req  = (stateQ == StIssue);
    imem.imem_addr = pcQ;
    if_valid       = ifValidQ;
    if_pc          = ifPcQ;
    if_instr       = ifInstrQ;
    opcode         = ifInstrQ[6:0];
  end

  pcAligned: assert property (@(posedge clock) disable iff (reset) pcQ[1:0] == 2'b00);
  singleCycleReq: assert property (@(posedge clock) disable iff (reset)
    !(imem.imem_req && $past(imem.imem_req)));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: credit-gated imem model, expected requests and IF/ID loads queued by
// the stimulus and checked by an independent monitor, plus a wrap-around instance.
module tb_fetch_stage;

  localparam logic [31:0] Nop     = 32'h0000_0013;
  localparam logic [63:0] WrapPc  = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        branchTaken;
  logic [63:0] branchTarget;
  logic        ifValid;
  logic [63:0] ifPc;
  logic [31:0] ifInstr;
  logic [6:0]  opcode;

  logic        ifValid2;
  logic [63:0] ifPc2;
  logic [31:0] ifInstr2;
  logic [6:0]  opcode2;

  int nChecks = 0;
  int nPass   = 0;

  // Memory model state: responses are released only while credits remain.
  int          credits = 0;
  int          lat     = 1;
  int          cnt     = 0;
  logic        pend    = 1'b0;
  logic [63:0] pendAddr;
  logic        pend2   = 1'b0;

  logic [63:0] expReq[$];
  logic [63:0] expPc[$];
  logic [31:0] expInstr[$];

  logic        prevValid = 1'b0;
  logic        prevStall = 1'b0;

  fetch_stage_if #(.XLEN(64)) imem ();
  fetch_stage_if #(.XLEN(64)) imem2 ();

  fetch_stage #(
    .XLEN     (64),
    .RESET_PC (64'h0),
    .NOP_INSTR(Nop)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branchTaken),
    .branch_target(branchTarget),
    .imem         (imem),
    .if_valid     (ifValid),
    .if_pc        (ifPc),
    .if_instr     (ifInstr),
    .opcode       (opcode)
  );

  fetch_stage #(
    .XLEN     (64),
    .RESET_PC (WrapPc),
    .NOP_INSTR(Nop)
  ) dutWrap (
    .clock        (clock),
    .reset        (reset),
    .stall        (1'b0),
    .branch_taken (1'b0),
    .branch_target(64'h0),
    .imem         (imem2),
    .if_valid     (ifValid2),
    .if_pc        (ifPc2),
    .if_instr     (ifInstr2),
    .opcode       (opcode2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] memWord(input logic [63:0] a);
    return 32'h0050_0093 ^ {a[19:0], 12'h000};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic waitValid(input string name);
    int n = 0;
    while (!ifValid && n < 40) begin
      @(negedge clock);
      n++;
    end
    check(name, 64'(ifValid), 64'd1);
  endtask

  task automatic waitCredits(input string name);
    int n = 0;
    while (credits != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check(name, 64'(credits), 64'd0);
  endtask

  // imem model for the main instance: latency lat, then waits for a credit.
  initial begin
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = 32'h0;
    forever begin
      @(posedge clock);
      #1;
      imem.imem_rvalid = 1'b0;
      if (pend) begin
        if (cnt > 0) cnt--;
        if (cnt == 0 && credits > 0) begin
          imem.imem_rvalid = 1'b1;
          imem.imem_rdata  = memWord(pendAddr);
          pend             = 1'b0;
          credits--;
        end
      end
      if (imem.imem_req) begin
        pend     = 1'b1;
        cnt      = lat;
        pendAddr = imem.imem_addr;
      end
    end
  end

  // imem model for the wrap instance: fixed one-cycle latency.
  initial begin
    imem2.imem_rvalid = 1'b0;
    imem2.imem_rdata  = 32'h0010_0093;
    forever begin
      @(posedge clock);
      #1;
      imem2.imem_rvalid = pend2;
      pend2             = imem2.imem_req;
    end
  end

  // Monitor: every request and every new IF/ID entry is matched against the queues.
  initial begin
    logic [63:0] ea;
    logic [31:0] ei;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (imem.imem_req) begin
          if (expReq.size() == 0) begin
            nChecks++;
            $display("FAIL req_unexpected: got request at %h, required none", imem.imem_addr);
          end else begin
            ea = expReq.pop_front();
            check("req_addr", imem.imem_addr, ea);
          end
        end
        if (ifValid && (!prevValid || !prevStall)) begin
          if (expPc.size() == 0) begin
            nChecks++;
            $display("FAIL ifid_unexpected: got pc %h instr %h, required none", ifPc, ifInstr);
          end else begin
            ea = expPc.pop_front();
            ei = expInstr.pop_front();
            check("ifid_pc", ifPc, ea);
            check("ifid_instr", 64'(ifInstr), 64'(ei));
            check("ifid_opcode", 64'(opcode), 64'(ei[6:0]));
          end
        end
      end
      prevValid = reset ? 1'b0 : ifValid;
      prevStall = stall;
    end
  end

  // Wrap instance: PC 2^64-4 must roll over to 0.
  initial begin
    int n;
    @(negedge reset);
    n = 0;
    while (!imem2.imem_req && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("wrap_req_seen", 64'(imem2.imem_req), 64'd1);
    check("wrap_first_addr", imem2.imem_addr, WrapPc);
    n = 0;
    while (!ifValid2 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("wrap_if_pc", ifPc2, WrapPc);
    check("wrap_next_req", 64'(imem2.imem_req), 64'd1);
    check("wrap_next_addr", imem2.imem_addr, 64'h0);
  end

  initial begin
    reset        = 1'b0;
    stall        = 1'b1;
    branchTaken  = 1'b0;
    branchTarget = 64'h0;
    #1;
    reset = 1'b1;

    expReq.push_back(64'h0);
    expReq.push_back(64'h4);
    expReq.push_back(64'h8);
    expPc.push_back(64'h0);  expInstr.push_back(32'h0050_0093);
    expPc.push_back(64'h4);  expInstr.push_back(32'h0050_4093);

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_if_valid", 64'(ifValid), 64'd0);
    check("rst_if_instr", 64'(ifInstr), 64'(Nop));
    check("rst_if_pc", ifPc, 64'h0);
    check("rst_opcode", 64'(opcode), 64'h13);
    check("rst_imem_req", 64'(imem.imem_req), 64'd0);

    // First word with IF/ID stalled: loads because IF/ID is empty.
    @(posedge clock); #2;
    reset   = 1'b0;
    credits = 1;
    waitValid("first_word_timeout");
    check("first_opcode", 64'(opcode), 64'(7'b0010011));
    check("first_if_pc", ifPc, 64'h0);

    // Second word arrives under stall: goes to skid, IF/ID holds.
    @(posedge clock); #2;
    credits = 1;
    waitCredits("second_word_timeout");
    repeat (2) @(negedge clock);
    check("full_hold_pc", ifPc, 64'h0);
    check("full_hold_instr", 64'(ifInstr), 64'h0050_0093);
    check("full_no_req", 64'(imem.imem_req), 64'd0);

    @(posedge clock); #2;
    stall = 1'b0;
    @(posedge clock); #2;
    stall = 1'b1;
    @(negedge clock);
    check("skid_if_pc", ifPc, 64'h4);
    check("skid_if_valid", 64'(ifValid), 64'd1);

    // Redirect while waiting on 0x8: response dropped, refetch at 0x100.
    expReq.push_back(64'h100);
    expReq.push_back(64'h104);
    expPc.push_back(64'h100); expInstr.push_back(32'h0040_0093);
    @(posedge clock); #2;
    branchTaken  = 1'b1;
    branchTarget = 64'h103;
    lat          = 3;
    @(posedge clock); #2;
    branchTaken = 1'b0;
    @(negedge clock);
    check("flush_if_valid", 64'(ifValid), 64'd0);
    check("flush_if_instr", 64'(ifInstr), 64'(Nop));
    @(posedge clock); #2;
    credits = 1;
    waitCredits("drop_word_timeout");
    repeat (2) @(negedge clock);
    check("drop_if_valid", 64'(ifValid), 64'd0);
    @(posedge clock); #2;
    credits = 1;
    waitValid("target_word_timeout");
    check("target_if_pc", ifPc, 64'h100);

    // Redirect, stall and rvalid together in WAIT: flush wins.
    expReq.push_back(64'h200);
    expReq.push_back(64'h204);
    expPc.push_back(64'h200); expInstr.push_back(32'h0070_0093);
    repeat (4) @(posedge clock);
    #2;
    credits = 1;
    @(posedge clock); #2;
    branchTaken  = 1'b1;
    branchTarget = 64'h200;
    @(posedge clock); #2;
    branchTaken = 1'b0;
    @(negedge clock);
    check("combo_if_valid", 64'(ifValid), 64'd0);
    check("combo_req", 64'(imem.imem_req), 64'd1);
    check("combo_addr", imem.imem_addr, 64'h200);
    @(posedge clock); #2;
    stall   = 1'b0;
    credits = 1;
    waitValid("combo_word_timeout");

    // Reset in the middle of WAIT; the late response lands during the next ISSUE.
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    check("mid_rst_if_valid", 64'(ifValid), 64'd0);
    check("mid_rst_if_instr", 64'(ifInstr), 64'(Nop));
    check("mid_rst_if_pc", ifPc, 64'h0);
    check("mid_rst_req", 64'(imem.imem_req), 64'd0);
    check("mid_rst_addr", imem.imem_addr, 64'h0);
    expReq.push_back(64'h0);
    expReq.push_back(64'h4);
    expPc.push_back(64'h0); expInstr.push_back(32'h0050_0093);
    repeat (4) @(posedge clock);
    #2;
    reset   = 1'b0;
    credits = 1;
    waitCredits("late_word_timeout");
    @(posedge clock); #2;
    credits = 1;
    waitValid("post_rst_word_timeout");
    check("post_rst_if_pc", ifPc, 64'h0);
    repeat (3) @(negedge clock);
    check("req_queue_drained", 64'(expReq.size()), 64'd0);
    check("ifid_queue_drained", 64'(expPc.size()), 64'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
